// File: rtl/uart_packet_rx.sv
// rtl/uart_packet_rx.sv - delimits SYNC/LEN/payload/CHK packets from a UART byte stream
// and releases checksum-verified payload words over a valid/ready handshake.
module uart_packet_rx #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_WORDS      = 4,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        word_last,
  input  logic        word_ready,
  output logic        busy,
  output logic [3:0]  err_status,
  input  logic        err_clear
);

  localparam int WIDX = $clog2(MAX_WORDS) + 1;
  localparam int AW   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [WIDX-1:0]   len_q, len_d, word_q, word_d, rd_q, rd_d, rd_nxt;
  logic [1:0]        byte_q, byte_d;
  logic [7:0]        acc_q, acc_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [31:0]       buf_q [MAX_WORDS];
  logic [31:0]       buf_d [MAX_WORDS];
  logic [31:0]       word_out_q, word_out_d;
  logic              word_valid_q, word_valid_d, word_last_q, word_last_d;
  logic              busy_q, busy_d;
  logic [3:0]        err_q, err_d, err_set;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_d       = word_q;
    rd_d         = rd_q;
    rd_nxt       = rd_q + WIDX'(1);
    byte_d       = byte_q;
    acc_d        = acc_q;
    tmo_d        = tmo_q;
    buf_d        = buf_q;
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q;
    word_last_d  = word_last_q;
    err_set      = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && !rx_error && rx_data == SYNC_BYTE) begin
          state_d = S_LEN;
          tmo_d   = '0;
        end
      end
      S_LEN, S_PAYLOAD, S_CHECK: begin
        if (rx_error) begin
          err_set[3] = 1'b1;
          state_d    = S_IDLE;
        end else if (rx_valid) begin
          tmo_d = '0;
          if (state_q == S_LEN) begin
            // Length is judged on all 8 bits so oversize values never alias.
            if (rx_data != 8'd0 && rx_data <= 8'(MAX_WORDS)) begin
              len_d   = rx_data[WIDX-1:0];
              acc_d   = rx_data;
              byte_d  = 2'd0;
              word_d  = '0;
              state_d = S_PAYLOAD;
            end else begin
              err_set[1] = 1'b1;
              state_d    = S_IDLE;
            end
          end else if (state_q == S_PAYLOAD) begin
            buf_d[word_q[AW-1:0]][{byte_q, 3'b000} +: 8] = rx_data;
            acc_d  = acc_q ^ rx_data;
            byte_d = byte_q + 2'd1;
            if (byte_q == 2'd3) begin
              word_d = word_q + WIDX'(1);
              if (word_q == len_q - WIDX'(1)) state_d = S_CHECK;
            end
          end else if (rx_data == acc_q) begin
            state_d      = S_DRAIN;
            rd_d         = '0;
            word_out_d   = buf_q[0];
            word_valid_d = 1'b1;
            word_last_d  = (len_q == WIDX'(1));
          end else begin
            err_set[0] = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (tmo_q == TMO_MAX) begin
          err_set[2] = 1'b1;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (rx_valid) err_set[3] = 1'b1;
        if (word_ready) begin
          if (word_last_q) begin
            word_valid_d = 1'b0;
            word_last_d  = 1'b0;
            state_d      = S_IDLE;
          end else begin
            rd_d        = rd_nxt;
            word_out_d  = buf_q[rd_nxt[AW-1:0]];
            word_last_d = (rd_nxt == len_q - WIDX'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new error in the same cycle as err_clear survives the clear.
    err_d  = (err_clear ? 4'b0000 : err_q) | err_set;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      word_q       <= '0;
      rd_q         <= '0;
      byte_q       <= '0;
      acc_q        <= '0;
      tmo_q        <= '0;
      buf_q        <= '{default: '0};
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_q       <= word_d;
      rd_q         <= rd_d;
      byte_q       <= byte_d;
      acc_q        <= acc_d;
      tmo_q        <= tmo_d;
      buf_q        <= buf_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      word_last_q  <= word_last_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign word_last  = word_last_q;
  assign busy       = busy_q;
  assign err_status = err_q;

endmodule
